// File: rtl/mux_serializer_pkg.sv
// Shared definitions for the mux serializer: state encodings and the
// gap-counter width helper.
package mux_serializer_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BIT0 = 2'd1;
    localparam logic [1:0] BIT1 = 2'd2;
    localparam logic [1:0] GAP  = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE = IDLE,
        ST_BIT0 = BIT0,
        ST_BIT1 = BIT1,
        ST_GAP  = GAP
    } state_t;

    // Width needed to hold the value gap_cycles, never less than one bit.
    function automatic int unsigned gap_cnt_w(input int unsigned gap_cycles);
        int unsigned w;
        w = $clog2(gap_cycles + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/mux_serializer_if.sv
// Bundle between the upstream word source, the serializer and the 2:1 mux.
//   dato_in/valid_in/ready_out : upstream word handshake
//   s/a/notoe                  : mux drive
//   busy/count                 : status
//   y_in/check_err             : mux readback check (MUX_SERIALIZER_CHECK_EN only)
// master: the serializer side; slave: the environment side.
interface mux_serializer_if #(
    parameter int unsigned CNT_W = 8
);
    logic [1:0]       dato_in;
    logic             valid_in;
    logic             ready_out;
    logic             s;
    logic [1:0]       a;
    logic             notoe;
    logic             busy;
    logic [CNT_W-1:0] count;
`ifdef MUX_SERIALIZER_CHECK_EN
    logic             y_in;
    logic             check_err;

    modport master (
        input  dato_in, valid_in, y_in,
        output ready_out, s, a, notoe, busy, count, check_err
    );
    modport slave (
        output dato_in, valid_in, y_in,
        input  ready_out, s, a, notoe, busy, count, check_err
    );
`else
    modport master (
        input  dato_in, valid_in,
        output ready_out, s, a, notoe, busy, count
    );
    modport slave (
        output dato_in, valid_in,
        input  ready_out, s, a, notoe, busy, count
    );
`endif
endinterface

// File: rtl/mux.sv
// Downstream 2:1 mux with active-low output enable; y floats when disabled.
//   s     : select (0 -> a[0], 1 -> a[1])
//   a     : data inputs
//   notoe : active-low output enable
//   y     : output
module mux (
    input  logic       s,
    input  logic [1:0] a,
    input  logic       notoe,
    output wire        y
);

    assign y = notoe ? 1'bz : (s ? a[1] : a[0]);

endmodule

// File: rtl/mux_gap_counter.sv
// Idle-gap down-counter. load presets the count; done_c is high on the last
// gap cycle (count of 1) and also when the count is zero, so a zero-length
// gap is bypassed immediately.
//   clk, reset : clock, synchronous active-high reset
//   load       : preset the counter with load_val
//   load_val   : gap length in cycles
//   done_c     : combinational, gap ends on this cycle's edge
module mux_gap_counter #(
    parameter int unsigned W = 1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done_c
);

    logic [W-1:0] cnt;

    // Count down to zero after a load, then hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - W'(1);
        end
    end

    assign done_c = (cnt <= W'(1));

endmodule

// File: rtl/mux_serializer.sv
// Serializes 2-bit words onto a downstream 2:1 mux: a[0] is presented with
// s=0, then a[1] with s=1, notoe low only during those two cycles, followed
// by GAP_CYCLES idle cycles. Counts completed words modulo 2^CNT_W.
// Ports:
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : mux_serializer_if.master (handshake, mux drive, status)
// Optional: MUX_SERIALIZER_CHECK_EN adds a sticky check of the mux output
// (bus.y_in) against the bit being presented (bus.check_err).
module mux_serializer
    import mux_serializer_pkg::*;
#(
    parameter int unsigned GAP_CYCLES = 1,
    parameter int unsigned CNT_W      = 8
) (
    input logic                clk,
    input logic                reset,
    mux_serializer_if.master   bus
);

    localparam int unsigned GW = gap_cnt_w(GAP_CYCLES);

    state_t           state;
    state_t           state_d;
    logic             s_d;
    logic             notoe_d;
    logic [1:0]       a_d;
    logic [CNT_W-1:0] count_d;
    logic             gap_load;
    logic             gap_done;
    logic             accept;

    assign bus.ready_out = (state == ST_IDLE) && !reset;
    assign bus.busy      = (state != ST_IDLE);
    assign accept        = bus.valid_in && bus.ready_out;

    // Next state and next registered outputs.
    always_comb begin
        state_d  = state;
        s_d      = bus.s;
        a_d      = bus.a;
        notoe_d  = bus.notoe;
        count_d  = bus.count;
        gap_load = 1'b0;
        case (state)
            ST_IDLE: begin
                if (accept) begin
                    a_d     = bus.dato_in;
                    s_d     = 1'b0;
                    notoe_d = 1'b0;
                    state_d = ST_BIT0;
                end
            end
            ST_BIT0: begin
                s_d     = 1'b1;
                state_d = ST_BIT1;
            end
            ST_BIT1: begin
                notoe_d = 1'b1;
                s_d     = 1'b0;
                count_d = bus.count + CNT_W'(1);
                if (GAP_CYCLES > 0) begin
                    gap_load = 1'b1;
                    state_d  = ST_GAP;
                end else begin
                    state_d  = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_done) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            bus.s     <= 1'b0;
            bus.a     <= 2'b00;
            bus.notoe <= 1'b1;
            bus.count <= '0;
        end else begin
            state     <= state_d;
            bus.s     <= s_d;
            bus.a     <= a_d;
            bus.notoe <= notoe_d;
            bus.count <= count_d;
        end
    end

    // Gap timing only exists when there is a gap to time.
    if (GAP_CYCLES > 0) begin : g_gap
        mux_gap_counter #(.W(GW)) u_gap (
            .clk      (clk),
            .reset    (reset),
            .load     (gap_load),
            .load_val (GW'(GAP_CYCLES)),
            .done_c   (gap_done)
        );
    end else begin : g_no_gap
        logic unused_gap_load;
        assign unused_gap_load = gap_load;
        assign gap_done        = 1'b1;
    end

`ifdef MUX_SERIALIZER_CHECK_EN
    logic mismatch;

    // Compare mux output against the bit presented in this cycle.
    always_comb begin
        mismatch = 1'b0;
        if (state == ST_BIT0) begin
            mismatch = (bus.y_in != bus.a[0]);
        end else if (state == ST_BIT1) begin
            mismatch = (bus.y_in != bus.a[1]);
        end
    end

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus.check_err <= 1'b0;
        end else if (mismatch) begin
            bus.check_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/mux_serializer.md
Name: mux_serializer

Overview:
- Sequential driver that sits directly upstream of the 2:1 `mux` (ports s, a[1:0], notoe, y).
- Accepts 2-bit parallel words over a valid/ready handshake and holds each word on `a`.
- Walks `s` through 0 then 1, with `notoe` low only while a word is being presented, so the mux emits the word serially on `y`, a[0] first.
- Inserts a programmable idle gap between words and counts completed words.

Parameters:
- GAP_CYCLES, 1, idle cycles with notoe=1 after each word (0 allowed).
- CNT_W, 8, width of the completed-word counter.

Ports:
- clk  in  1  system clock, rising-edge
- reset  in  1  synchronous, active-high
- dato_in  in  2  parallel word from upstream
- valid_in  in  1  dato_in is valid
- ready_out  out  1  block can accept a word this cycle
- s  out  1  mux select, to mux.s
- a  out  2  mux data inputs, to mux.a
- notoe  out  1  active-low mux output enable, to mux.notoe
- busy  out  1  high in any state other than IDLE
- count  out  CNT_W  completed words, wraps modulo 2^CNT_W

Behaviour:
- Interface: one clock (clk). Reset is synchronous and active-high (reset). Every register updates only on the rising edge of clk.
- Reset values: state=IDLE, s=0, a=2'b00, notoe=1, count=0, gap counter=0. While reset is high, ready_out=0. ready_out rises the first cycle after reset deasserts.
- Outputs s, a, notoe and count are registered. ready_out=(state==IDLE)&&!reset and busy=(state!=IDLE) are combinational from state.
- States:
  - IDLE:
    - ready_out=1, notoe=1, s=0.
    - On a clk edge with valid_in&&ready_out: a<=dato_in, s<=0, notoe<=0, go to BIT0.
  - BIT0:
    - Lasts exactly 1 cycle; mux presents a[0].
    - Next edge: s<=1, go to BIT1.
  - BIT1:
    - Lasts exactly 1 cycle; mux presents a[1].
    - Next edge: notoe<=1, s<=0, count<=count+1.
    - Go to GAP if GAP_CYCLES>0, otherwise go to IDLE.
  - GAP:
    - notoe=1, ready_out=0.
    - Stays exactly GAP_CYCLES cycles, then goes to IDLE.
- Stability: `a` is constant from the BIT0 entry edge until the next capture. It keeps its last value through GAP and IDLE. s and notoe never change on the same edge as `a`, except at capture.
- Throughput: one word per 3+GAP_CYCLES cycles when valid_in is held high.
- valid_in while ready_out=0: ignored, no capture. Upstream must hold dato_in/valid_in until it sees ready_out=1.
- Changes on dato_in during BIT0/BIT1/GAP have no effect.
- count wraps from 2^CNT_W-1 to 0 without a flag.
- Reset mid-word (BIT0, BIT1 or GAP): all outputs return to reset values on that edge. The word in flight is dropped, and count is cleared, not incremented.

Optional Feature:
- Macro: MUX_SERIALIZER_CHECK_EN.
- Defined:
  - Adds input y_in (1 bit, from mux.y) and output check_err (1 bit, sticky).
  - At the edge that ends BIT0, y_in is compared against a[0]; at the edge that ends BIT1, against a[1].
  - A mismatch sets check_err=1. It clears only on reset (reset value 0).
  - The comparison is skipped in IDLE and GAP.
- Undefined: neither port exists and there is no compare logic.

Decomposition:
- Package mux_serializer_pkg holds:
  - state encoding localparams: IDLE=2'd0, BIT0=2'd1, BIT1=2'd2, GAP=2'd3;
  - a function for the gap-counter width, $clog2(GAP_CYCLES+1) with a minimum of 1.
- One natural sub-module: mux_gap_counter, a down-counter with load, done and zero-length bypass, instantiated only when GAP_CYCLES>0.
- The bench instantiates mux_serializer feeding `mux` directly.

Test Plan:
1. Reset then idle: hold reset 2 cycles, release, no valid -> s=0, a=00, notoe=1, ready_out=1, count=0.
2. Single word: dato_in=2'b10, valid_in 1 cycle -> BIT0 cycle s=0, notoe=0, mux y=0; BIT1 cycle s=1, y=1; then notoe=1, y=Z, count=1, ready_out returns after 1 GAP cycle.
3. Back-to-back with GAP_CYCLES=0: valid_in held high with words 01,11,00 -> captures every 3 cycles, count=3 after 9 cycles, notoe high exactly 1 cycle between words.
4. Held and ignored input: valid_in=1 with dato_in toggling during BIT0/BIT1 -> `a` unchanged; next capture takes the value present on the IDLE edge.
5. Reset mid-word: assert reset during BIT1 of word 11 -> next edge notoe=1, s=0, a=00, count=0; the word is not counted.
6. With MUX_SERIALIZER_CHECK_EN: force y_in to 0 during BIT1 of word 10 -> check_err=1 from the following edge, stays 1 through later good words until reset.
